// File: rtl/param_shift_reg.sv
// Parametrised storage/shift element: parallel load, serial shift, rotate,
// synchronous preset and increment with a registered carry out.
module param_shift_reg #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             sout_l,
  output logic             sout_r
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // An unknown mode poisons q and co so that the problem shows up in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= RESET_VALUE;
      co <= 1'b0;
    end else if (e) begin
      case (mode)
        3'b000: begin q <= q;                            co <= 1'b0; end
        3'b001: begin q <= d;                            co <= 1'b0; end
        3'b010: begin q <= {q[WIDTH-2:0], sin_l};        co <= 1'b0; end
        3'b011: begin q <= {sin_r, q[WIDTH-1:1]};        co <= 1'b0; end
        3'b100: begin q <= {q[WIDTH-2:0], q[WIDTH-1]};   co <= 1'b0; end
        3'b101: begin q <= {q[0], q[WIDTH-1:1]};         co <= 1'b0; end
        3'b110: begin q <= PRESET_VALUE;                 co <= 1'b0; end
        3'b111: begin q <= q + ONE;                      co <= &q;   end
        default: begin q <= 'x;                          co <= 1'bx; end
      endcase
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed and randomised checks of param_shift_reg (WIDTH=8, RESET_VALUE=8'h5A).
module tb_param_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       e;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       co;
  logic       sout_l;
  logic       sout_r;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq;
  logic       mco;

  param_shift_reg #(
    .WIDTH(8),
    .RESET_VALUE(8'h5A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .e(e),
    .mode(mode),
    .d(d),
    .sin_l(sin_l),
    .sin_r(sin_r),
    .q(q),
    .co(co),
    .sout_l(sout_l),
    .sout_r(sout_r)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic te, input logic [2:0] tmode, input logic [7:0] td,
                               input logic tsl, input logic tsr);
    e     = te;
    mode  = tmode;
    d     = td;
    sin_l = tsl;
    sin_r = tsr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_q, input logic exp_co);
    checks++;
    assert (q === exp_q) else begin
      errors++;
      $error("[TB] FAIL %s q got %h expected %h", tag, q, exp_q);
    end
    checks++;
    assert (co === exp_co) else begin
      errors++;
      $error("[TB] FAIL %s co got %b expected %b", tag, co, exp_co);
    end
    checks++;
    assert ({sout_l, sout_r} === {exp_q[7], exp_q[0]}) else begin
      errors++;
      $error("[TB] FAIL %s sout got %b%b expected %b%b", tag, sout_l, sout_r, exp_q[7], exp_q[0]);
    end
  endtask

  // Independent reference written with shifts and a 9-bit sum.
  task automatic modelStep(input logic te, input logic [2:0] tmode, input logic [7:0] td,
                           input logic tsl, input logic tsr);
    logic [8:0] sum;
    if (!te) return;
    mco = 1'b0;
    case (tmode)
      3'd0: mq = mq;
      3'd1: mq = td;
      3'd2: mq = (mq << 1) | {7'd0, tsl};
      3'd3: mq = (mq >> 1) | {tsr, 7'd0};
      3'd4: mq = (mq << 1) | (mq >> 7);
      3'd5: mq = (mq >> 1) | (mq << 7);
      3'd6: mq = 8'hFF;
      default: begin
        sum = {1'b0, mq} + 9'd1;
        mq  = sum[7:0];
        mco = sum[8];
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; e = 1'b0; mode = 3'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    #3;
    checkOutput("reset_initial", 8'h5A, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(1'b1, 3'b001, 8'h12, 1'b0, 1'b0);
    checkOutput("load_12", 8'h12, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("reset_midcycle", 8'h5A, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 3'b000, 8'h00, 1'b1, 1'b1);
    checkOutput("hold_after_reset", 8'h5A, 1'b0);

    applyStimulus(1'b0, 3'b001, 8'hC3, 1'b0, 1'b0);
    checkOutput("load_disabled", 8'h5A, 1'b0);
    applyStimulus(1'b1, 3'b001, 8'hC3, 1'b0, 1'b0);
    checkOutput("load_C3", 8'hC3, 1'b0);

    applyStimulus(1'b1, 3'b010, 8'h00, 1'b0, 1'b1);
    checkOutput("shift_left", 8'h86, 1'b0);
    applyStimulus(1'b1, 3'b011, 8'h00, 1'b1, 1'b1);
    checkOutput("shift_right", 8'hC3, 1'b0);

    applyStimulus(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
    checkOutput("load_81", 8'h81, 1'b0);
    applyStimulus(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    checkOutput("rotate_left", 8'h03, 1'b0);
    applyStimulus(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    checkOutput("rotate_right_1", 8'h81, 1'b0);
    applyStimulus(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    checkOutput("rotate_right_2", 8'hC0, 1'b0);

    applyStimulus(1'b1, 3'b001, 8'hFE, 1'b0, 1'b0);
    checkOutput("load_FE", 8'hFE, 1'b0);
    applyStimulus(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    checkOutput("inc_to_FF", 8'hFF, 1'b0);
    applyStimulus(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    checkOutput("inc_wrap", 8'h00, 1'b1);
    applyStimulus(1'b0, 3'b111, 8'h00, 1'b0, 1'b0);
    checkOutput("carry_hold", 8'h00, 1'b1);
    applyStimulus(1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    checkOutput("carry_clear", 8'h00, 1'b0);

    applyStimulus(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    checkOutput("preset", 8'hFF, 1'b0);

    mq  = 8'hFF;
    mco = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic       re;
      logic [2:0] rmode;
      logic [7:0] rd;
      logic       rsl;
      logic       rsr;
      re    = ($urandom_range(0, 3) != 0);
      rmode = 3'($urandom_range(0, 7));
      rd    = 8'($urandom);
      rsl   = 1'($urandom);
      rsr   = 1'($urandom);
      applyStimulus(re, rmode, rd, rsl, rsr);
      modelStep(re, rmode, rd, rsl, rsr);
      checkOutput("random", mq, mco);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        #2;
        mq  = 8'h5A;
        mco = 1'b0;
        checkOutput("random_reset", mq, mco);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
